// File: rtl/dcf77_pkg.sv
// Shared types, frame field offsets and the minute-frame content check for the
// DCF77 receiver.
package dcf77_pkg;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_NOSYNC  = 3'd1,
    ERR_LENGTH  = 3'd2,
    ERR_PULSE   = 3'd3,
    ERR_CONTENT = 3'd4,
    ERR_LOSS    = 3'd5
  } err_t;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int unsigned OFS_START      = 0;
  localparam int unsigned OFS_LEAP_ANN   = 19;
  localparam int unsigned OFS_TIME_START = 20;
  localparam int unsigned OFS_MIN        = 21;
  localparam int unsigned OFS_P1         = 28;
  localparam int unsigned OFS_HOUR       = 29;
  localparam int unsigned OFS_P2         = 35;
  localparam int unsigned OFS_DAY        = 36;
  localparam int unsigned OFS_WDAY       = 42;
  localparam int unsigned OFS_MON        = 45;
  localparam int unsigned OFS_YEAR       = 50;
  localparam int unsigned OFS_P3         = 58;

  function automatic logic bcd_in(input logic [3:0] units, input logic [3:0] tens,
                                  input int unsigned lo, input int unsigned hi);
    int unsigned v;
    v = 10 * 32'(tens) + 32'(units);
    return (units < 4'd10) && (v >= lo) && (v <= hi);
  endfunction

  function automatic logic frame_ok(input logic [58:0] f);
    logic ok;
    ok = ~f[OFS_START] & f[OFS_TIME_START];
    ok &= ~^f[OFS_P1:OFS_MIN];
    ok &= ~^f[OFS_P2:OFS_HOUR];
    ok &= ~^f[OFS_P3:OFS_DAY];
    ok &= bcd_in(f[OFS_MIN +: 4], {1'b0, f[OFS_MIN+4 +: 3]}, 0, 59);
    ok &= bcd_in(f[OFS_HOUR +: 4], {2'b0, f[OFS_HOUR+4 +: 2]}, 0, 23);
    ok &= bcd_in(f[OFS_DAY +: 4], {2'b0, f[OFS_DAY+4 +: 2]}, 1, 31);
    ok &= (f[OFS_WDAY +: 3] != 3'd0);
    ok &= bcd_in(f[OFS_MON +: 4], {3'b0, f[OFS_MON+4]}, 1, 12);
    ok &= bcd_in(f[OFS_YEAR +: 4], f[OFS_YEAR+4 +: 4], 0, 99);
    return ok;
  endfunction

endpackage

// File: rtl/dcf77_pulse_filter.sv
// Synchronises the raw DCF77 pulse, rejects short glitches with a majority vote
// and produces tick-aligned rise/fall strobes.
module dcf77_pulse_filter #(
  parameter int unsigned FILTER_TAPS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic rx,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [1:0]             sync_q;
  logic [FILTER_TAPS-1:0] taps;
  logic [1:0]             edge_q;
  logic [2:0]             ones;
  logic                   maj;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < FILTER_TAPS; i++) begin
      ones = ones + 3'(taps[i]);
    end
    maj = (ones > 3'(FILTER_TAPS / 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      taps   <= '0;
      edge_q <= '0;
    end else if (clk_en) begin
      sync_q <= {sync_q[0], rx};
      taps   <= {taps[FILTER_TAPS-2:0], sync_q[1]};
      edge_q <= {edge_q[0], maj};
    end
  end

  // Registered pipe keeps rise and fall mutually exclusive within a tick.
  assign rise  = edge_q[0] & ~edge_q[1];
  assign fall  = ~edge_q[0] & edge_q[1];
  assign level = edge_q[0];

endmodule

// File: rtl/dcf77_rx_gen.sv
// DCF77 minute-frame receiver: pulse classification, second indexing, minute
// gap detection with leap-second length handling and frame validation.
module dcf77_rx_gen
  import dcf77_pkg::*;
#(
  parameter int unsigned TICK_PER_SEC = 100,
  parameter int unsigned FILTER_TAPS  = 3,
  parameter int unsigned BIT_THRESH   = 15,
  parameter int unsigned PULSE_MIN    = 5,
  parameter int unsigned PULSE_MAX    = 25,
  parameter int unsigned GAP_MIN      = 150,
  parameter int unsigned LOSS_TICKS   = 250,
  parameter int unsigned FRAME_BITS   = 59
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  rx,
  output logic [FRAME_BITS-1:0] data_hold,
  output logic [2:0]            err_code,
  output logic                  error,
  output logic                  locked,
  output logic [5:0]            bit_count,
  output logic                  sync
);

  if (FILTER_TAPS < 3 || FILTER_TAPS > 7 || FILTER_TAPS % 2 == 0 || TICK_PER_SEC == 0)
  begin : g_param_check
    $error("dcf77_rx_gen: FILTER_TAPS must be odd in 3..7 and TICK_PER_SEC nonzero");
  end

  localparam logic [5:0] THRESH_W = 6'(BIT_THRESH);
  localparam logic [5:0] PMIN_W   = 6'(PULSE_MIN);
  localparam logic [5:0] PMAX_W   = 6'(PULSE_MAX);
  localparam logic [8:0] GAP_W    = 9'(GAP_MIN);
  localparam logic [8:0] LOSS_W   = 9'(LOSS_TICKS);
  localparam logic [5:0] FB_W     = 6'(FRAME_BITS);
  localparam logic [5:0] FB_LEAP  = 6'(FRAME_BITS + 1);

  logic rise, fall, level;

  dcf77_pulse_filter #(
    .FILTER_TAPS(FILTER_TAPS)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .rx    (rx),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  state_t                state;
  err_t                  err_q;
  logic [5:0]            width;
  logic [8:0]            spacing;
  logic [FRAME_BITS-1:0] data_shift;
  logic                  pulse_err;
  logic                  close_pend;
  logic                  frame_valid;

  logic       d, bad_width, gap, loss;
  logic [5:0] exp_len;

  always_comb begin
    d         = (width >= THRESH_W);
    bad_width = (width < PMIN_W) || (width > PMAX_W);
    gap       = (spacing > GAP_W);
    loss      = (spacing == LOSS_W);
    exp_len   = data_shift[OFS_LEAP_ANN] ? FB_LEAP : FB_W;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      err_q       <= ERR_NOSYNC;
      width       <= '0;
      spacing     <= '0;
      data_shift  <= '0;
      data_hold   <= '0;
      bit_count   <= '0;
      pulse_err   <= 1'b0;
      close_pend  <= 1'b0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
    end else if (clk_en) begin
      frame_valid <= 1'b0;

      if (rise)               width <= 6'd1;
      else if (level && width != '1) width <= width + 6'd1;

      if (rise)               spacing <= '0;
      else if (spacing != '1) spacing <= spacing + 9'd1;

      // Loss outranks a pending frame close in the same tick.
      if (loss) begin
        err_q      <= ERR_LOSS;
        locked     <= 1'b0;
        state      <= HUNT;
        close_pend <= 1'b0;
        bit_count  <= '0;
        pulse_err  <= 1'b0;
        data_shift <= '0;
      end else if (state == HUNT) begin
        if (rise && gap) begin
          state      <= RECV;
          bit_count  <= '0;
          pulse_err  <= 1'b0;
          data_shift <= '0;
        end
      end else if (close_pend) begin
        close_pend <= 1'b0;
        if (bit_count != exp_len)             err_q <= ERR_LENGTH;
        else if (pulse_err)                   err_q <= ERR_PULSE;
        else if (!frame_ok(59'(data_shift)))  err_q <= ERR_CONTENT;
        else begin
          err_q       <= ERR_NONE;
          data_hold   <= data_shift;
          frame_valid <= 1'b1;
          locked      <= 1'b1;
        end
        bit_count  <= '0;
        pulse_err  <= 1'b0;
        data_shift <= '0;
      end else if (rise && gap) begin
        close_pend <= 1'b1;
      end else if (fall) begin
        if (bit_count < FB_W) data_shift[bit_count] <= d;
        pulse_err <= pulse_err | bad_width | ((bit_count == FB_W) & d);
        if (bit_count != '1) bit_count <= bit_count + 6'd1;
      end
    end
  end

  assign err_code = err_q;
  assign error    = (err_q != ERR_NONE);
  assign sync     = frame_valid & clk_en;

endmodule

// File: tb/tb_dcf77_rx_gen.sv
// Scoreboard bench for dcf77_rx_gen: drives whole minute frames on rx and
// checks each frame close / loss / reset outcome against queued expectations.
`timescale 1ns/1ps
module tb_dcf77_rx_gen;
  import dcf77_pkg::*;

  // Compressed timebase: a 40-tick second keeps whole-minute runs short.
  localparam int SEC = 40;

  logic        clk, rst, clk_en, rx;
  logic [58:0] data_hold;
  logic [2:0]  err_code;
  logic        error, locked, sync;
  logic [5:0]  bit_count;

  dcf77_rx_gen #(
    .TICK_PER_SEC(SEC),
    .FILTER_TAPS (3),
    .BIT_THRESH  (15),
    .PULSE_MIN   (5),
    .PULSE_MAX   (25),
    .GAP_MIN     (60),
    .LOSS_TICKS  (100),
    .FRAME_BITS  (59)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .rx       (rx),
    .data_hold(data_hold),
    .err_code (err_code),
    .error    (error),
    .locked   (locked),
    .bit_count(bit_count),
    .sync     (sync)
  );

  typedef struct {
    logic [2:0]  err;
    logic [58:0] hold;
    logic        lck;
    int          syncs;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_syncs = 0;
  int   sync_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1 clk_en = ~clk_en;
    end
  end

  always @(negedge clk) if (sync) sync_cnt <= sync_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (clk_en !== 1'b1);
    end
    #2;
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    ticks(n);
  endtask

  task automatic send_sec(input int w, input bit glitch);
    if (!glitch) begin
      drive(1'b1, w);
      drive(1'b0, SEC - w);
    end else begin
      drive(1'b1, w / 2);
      drive(1'b0, 1);
      drive(1'b1, w - w / 2 - 1);
      drive(1'b0, 10);
      drive(1'b1, 1);
      drive(1'b0, SEC - w - 11);
    end
  endtask

  task automatic send_frame(input logic [58:0] f, input int nbits, input int bad, input bit glitch);
    logic b;
    int   w;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 59) ? f[i] : 1'b0;
      w = b ? 20 : 10;
      if (i == bad) w = 3;
      send_sec(w, glitch);
    end
    drive(1'b0, SEC);
  endtask

  function automatic logic [58:0] mk_frame(input int mi, input int hr, input int dy,
                                           input int wd, input int mo, input int yr);
    logic [58:0] f;
    f = '0;
    f[20]    = 1'b1;
    f[24:21] = 4'(mi % 10);
    f[27:25] = 3'(mi / 10);
    f[28]    = ^f[27:21];
    f[32:29] = 4'(hr % 10);
    f[34:33] = 2'(hr / 10);
    f[35]    = ^f[34:29];
    f[39:36] = 4'(dy % 10);
    f[41:40] = 2'(dy / 10);
    f[44:42] = 3'(wd);
    f[48:45] = 4'(mo % 10);
    f[49]    = 1'(mo / 10);
    f[53:50] = 4'(yr % 10);
    f[57:54] = 4'(yr / 10);
    f[58]    = ^f[57:36];
    return f;
  endfunction

  task automatic push_exp(input logic [2:0] err, input logic [58:0] hold, input logic lck);
    exp_t e;
    e.err = err; e.hold = hold; e.lck = lck; e.syncs = exp_syncs;
    sb.push_back(e);
  endtask

  // Every frame close, loss or reset clears a nonzero bit_count.
  initial begin
    logic [5:0] prev;
    exp_t       e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (prev != 6'd0 && bit_count == 6'd0) begin
        repeat (4) @(negedge clk);
        if (sb.size() == 0) begin
          chk("sb_event_expected", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("err_code", 64'(err_code), 64'(e.err));
          chk("error", 64'(error), 64'(e.err != 3'd0));
          chk("data_hold", 64'(data_hold), 64'(e.hold));
          chk("locked", 64'(locked), 64'(e.lck));
          chk("sync_cnt", 64'(sync_cnt), 64'(e.syncs));
        end
      end
      prev = bit_count;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [58:0] fa, fb, fl, f2;
    rst = 1'b1;
    rx  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_err_code", 64'(err_code), 64'(ERR_NOSYNC));
    chk("rst_error", 64'(error), 64'd1);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_bit_count", 64'(bit_count), 64'd0);
    chk("rst_data_hold", 64'(data_hold), 64'd0);
    chk("rst_sync", 64'(sync), 64'd0);
    @(negedge clk) rst = 1'b0;

    drive(1'b0, 80);
    fa = mk_frame(34, 12, 15, 5, 3, 24);
    fb = mk_frame(59, 23, 31, 7, 12, 99);

    send_frame(fa, 59, -1, 1'b0); exp_syncs++; push_exp(ERR_NONE, fa, 1'b1);
    f2 = fa; f2[22] = ~f2[22];
    send_frame(f2, 59, -1, 1'b0); push_exp(ERR_CONTENT, fa, 1'b1);
    send_frame(fa, 58, -1, 1'b0); push_exp(ERR_LENGTH, fa, 1'b1);
    send_frame(fa, 59, 5, 1'b0);  push_exp(ERR_PULSE, fa, 1'b1);
    fl = fa; fl[19] = 1'b1;
    send_frame(fl, 60, -1, 1'b0); exp_syncs++; push_exp(ERR_NONE, fl, 1'b1);
    send_frame(fa, 60, -1, 1'b0); push_exp(ERR_LENGTH, fl, 1'b1);
    send_frame(fb, 59, -1, 1'b1); exp_syncs++; push_exp(ERR_NONE, fb, 1'b1);

    send_sec(10, 1'b0);
    push_exp(ERR_LOSS, fb, 1'b0);
    drive(1'b0, 110);

    send_frame(fa, 59, -1, 1'b0); exp_syncs++; push_exp(ERR_NONE, fa, 1'b1);
    send_sec(10, 1'b0);
    for (int i = 0; i < 10; i++) send_sec(20, 1'b0);
    chk("bit_count_mid", 64'(bit_count), 64'd11);

    push_exp(ERR_NOSYNC, '0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_err_code", 64'(err_code), 64'(ERR_NOSYNC));
    chk("arst_locked", 64'(locked), 64'd0);
    chk("arst_data_hold", 64'(data_hold), 64'd0);
    chk("arst_bit_count", 64'(bit_count), 64'd0);
    repeat (10) @(posedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
